// File: rtl/depp_reg_arbiter.sv
// DEPP host sequencer sharing an 8-bit register file with one fabric port.
// Optional DEPP_AUTOINC_EN: addr_reg post-increments after host data transfers.
module depp_reg_arbiter #(
   parameter int AW   = 4,
   parameter int SYNC = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_astb,
   input  logic          a_dstb,
   input  logic          a_write,
   input  logic [7:0]    a_db_i,
   output logic [7:0]    a_db_o,
   output logic          a_db_oe,
   output logic          a_wait,
   output logic [7:0]    addr_reg,
   input  logic          f_req,
   input  logic          f_we,
   input  logic [AW-1:0] f_addr,
   input  logic [7:0]    f_wdata,
   output logic          f_gnt,
   output logic [7:0]    f_rdata,
   output logic          f_rvalid
);

   localparam int DEPTH = 1 << AW;

`ifdef DEPP_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      DREQ,
      DREAD,
      HOLD
   } state_t;

   state_t          state;
   logic [SYNC-1:0] astb_sync;
   logic [SYNC-1:0] dstb_sync;
   logic            astb_hist;
   logic            dstb_hist;
   logic            a_fall;
   logic            a_rise;
   logic            d_fall;
   logic            d_rise;
   logic            act_rise;

   logic [7:0]      mem [DEPTH];
   logic [7:0]      data_q;
   logic [7:0]      host_rd;
   logic            wr_n_q;
   logic            act_d;
   logic            last_host;
   logic            host_req;
   logic            gnt_f;
   logic            gnt_h;
   logic [AW-1:0]   host_idx;

   // Synchronisers reset to the asserted level so a held strobe gives no edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         astb_sync <= '0;
         dstb_sync <= '0;
         astb_hist <= 1'b0;
         dstb_hist <= 1'b0;
      end else begin
         astb_sync <= {astb_sync[SYNC-2:0], a_astb};
         dstb_sync <= {dstb_sync[SYNC-2:0], a_dstb};
         astb_hist <= astb_sync[SYNC-1];
         dstb_hist <= dstb_sync[SYNC-1];
      end
   end

   assign a_fall   = ~astb_sync[SYNC-1] & astb_hist;
   assign a_rise   = astb_sync[SYNC-1] & ~astb_hist;
   assign d_fall   = ~dstb_sync[SYNC-1] & dstb_hist;
   assign d_rise   = dstb_sync[SYNC-1] & ~dstb_hist;
   assign act_rise = act_d ? d_rise : a_rise;

   assign host_idx = addr_reg[AW-1:0];
   assign host_req = (state == DREQ);
   assign gnt_f    = ~rst & f_req & (~host_req | last_host);
   assign gnt_h    = ~rst & host_req & ~gnt_f;
   assign f_gnt    = gnt_f;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (gnt_f && f_we) begin
         mem[f_addr] <= f_wdata;
      end else if (gnt_h && !wr_n_q) begin
         mem[host_idx] <= data_q;
      end
   end

   // last_host=1 makes the fabric the preferred requester on a tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_host <= 1'b1;
         f_rvalid  <= 1'b0;
         f_rdata   <= '0;
      end else begin
         if (gnt_f || gnt_h) last_host <= gnt_h;
         f_rvalid <= gnt_f & ~f_we;
         if (gnt_f && !f_we) f_rdata <= mem[f_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         a_db_o   <= '0;
         a_db_oe  <= 1'b0;
         a_wait   <= 1'b0;
         addr_reg <= '0;
         data_q   <= '0;
         host_rd  <= '0;
         wr_n_q   <= 1'b1;
         act_d    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (a_fall) begin
                  state  <= ADDR;
                  act_d  <= 1'b0;
                  wr_n_q <= a_write;
                  data_q <= a_db_i;
               end else if (d_fall) begin
                  state  <= DREQ;
                  act_d  <= 1'b1;
                  wr_n_q <= a_write;
                  data_q <= a_db_i;
               end
            end
            ADDR: begin
               if (!wr_n_q) begin
                  addr_reg <= data_q;
               end else begin
                  a_db_o  <= addr_reg;
                  a_db_oe <= 1'b1;
               end
               state <= HOLD;
            end
            DREQ: begin
               if (gnt_h) begin
                  if (!wr_n_q) begin
                     state <= HOLD;
                     if (AUTOINC) addr_reg <= addr_reg + 8'd1;
                  end else begin
                     host_rd <= mem[host_idx];
                     state   <= DREAD;
                  end
               end
            end
            DREAD: begin
               a_db_o  <= host_rd;
               a_db_oe <= 1'b1;
               state   <= HOLD;
               if (AUTOINC) addr_reg <= addr_reg + 8'd1;
            end
            HOLD: begin
               if (act_rise) begin
                  a_wait  <= 1'b0;
                  a_db_oe <= 1'b0;
                  state   <= IDLE;
               end else begin
                  a_wait <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_depp_reg_arbiter.sv
// Self-checking bench for depp_reg_arbiter: vector table, hand corner cases,
// and randomized host/fabric traffic against a simple register-file model.
module tb_depp_reg_arbiter;

   localparam int AW    = 4;
   localparam int SYNC  = 2;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          a_astb;
   logic          a_dstb;
   logic          a_write;
   logic [7:0]    a_db_i;
   logic [7:0]    a_db_o;
   logic          a_db_oe;
   logic          a_wait;
   logic [7:0]    addr_reg;
   logic          f_req;
   logic          f_we;
   logic [AW-1:0] f_addr;
   logic [7:0]    f_wdata;
   logic          f_gnt;
   logic [7:0]    f_rdata;
   logic          f_rvalid;

   int checks = 0;
   int passed = 0;

   logic [7:0] mdl_mem [DEPTH];
   logic [7:0] mdl_addr;

   typedef struct {
      int         kind;
      logic [7:0] din;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   depp_reg_arbiter #(.AW(AW), .SYNC(SYNC)) dut (
      .clk      (clk),
      .rst      (rst),
      .a_astb   (a_astb),
      .a_dstb   (a_dstb),
      .a_write  (a_write),
      .a_db_i   (a_db_i),
      .a_db_o   (a_db_o),
      .a_db_oe  (a_db_oe),
      .a_wait   (a_wait),
      .addr_reg (addr_reg),
      .f_req    (f_req),
      .f_we     (f_we),
      .f_addr   (f_addr),
      .f_wdata  (f_wdata),
      .f_gnt    (f_gnt),
      .f_rdata  (f_rdata),
      .f_rvalid (f_rvalid)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic mdl_reset();
      for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 8'h00;
      mdl_addr = 8'h00;
   endtask

   task automatic mdl_bump();
`ifdef DEPP_AUTOINC_EN
      mdl_addr = mdl_addr + 8'd1;
`endif
   endtask

   // kind: 0 addr write, 1 addr read, 2 data write, 3 data read.
   task automatic mdl_host(input int kind, input logic [7:0] d,
                           output logic [7:0] exp);
      exp = 8'h00;
      case (kind)
         0: begin mdl_addr = d; exp = d; end
         1: exp = mdl_addr;
         2: begin
            mdl_mem[mdl_addr[AW-1:0]] = d;
            mdl_bump();
            exp = mdl_addr;
         end
         default: begin
            exp = mdl_mem[mdl_addr[AW-1:0]];
            mdl_bump();
         end
      endcase
   endtask

   task automatic add_vec(input int k, input logic [7:0] di,
                          input logic [7:0] ex);
      vec_t v;
      v.kind = k;
      v.din  = di;
      v.exp  = ex;
      tbl.push_back(v);
   endtask

   task automatic wait_drop(input string name);
      int n;
      n = 0;
      while (a_wait && n < 40) begin @(negedge clk); n++; end
      check(name, a_wait, 1'b0);
   endtask

   // Returns addr_reg for writes, a_db_o for reads, sampled while a_wait=1.
   task automatic host_op(input int kind, input logic [7:0] d,
                          output logic [7:0] r);
      int n;
      bit is_data;
      bit is_wr;
      is_data = (kind >= 2);
      is_wr   = (kind == 0 || kind == 2);
      @(negedge clk);
      a_write = ~is_wr;
      a_db_i  = d;
      if (is_data) a_dstb = 1'b0;
      else a_astb = 1'b0;
      n = 0;
      while (!a_wait && n < 40) begin @(negedge clk); n++; end
      check("host_wait_rise", a_wait, 1'b1);
      if (!is_wr) check("host_read_oe", a_db_oe, 1'b1);
      r = is_wr ? addr_reg : a_db_o;
      a_astb = 1'b1;
      a_dstb = 1'b1;
      wait_drop("host_wait_drop");
      a_write = 1'b1;
   endtask

   task automatic fab_op(input bit we, input logic [AW-1:0] a,
                         input logic [7:0] d, output logic [7:0] r);
      int n;
      @(negedge clk);
      f_req   = 1'b1;
      f_we    = we;
      f_addr  = a;
      f_wdata = d;
      #1;
      n = 0;
      while (!f_gnt && n < 20) begin @(negedge clk); #1; n++; end
      check("fab_gnt", f_gnt, 1'b1);
      @(negedge clk);
      f_req = 1'b0;
      #1;
      check("fab_rvalid", f_rvalid, !we);
      r = f_rdata;
      @(negedge clk);
      #1;
      check("fab_rvalid_pulse", f_rvalid, 1'b0);
   endtask

   // Host data read of addr 3 contended by a fabric write to addr 3.
   task automatic contend(input logic [7:0] wd, input bit fab_first,
                          input logic [7:0] exp_rd);
      int n;
      bit first;
      @(negedge clk);
      a_write = 1'b1;
      a_dstb  = 1'b0;
      repeat (SYNC + 1) @(posedge clk);
      @(negedge clk);
      f_req   = 1'b1;
      f_we    = 1'b1;
      f_addr  = 3;
      f_wdata = wd;
      #1;
      first = f_gnt;
      check("contend_fab_first", first, fab_first);
      n = 0;
      while (!f_gnt && n < 10) begin @(negedge clk); #1; n++; end
      check("contend_fab_gnt", f_gnt, 1'b1);
      @(negedge clk);
      f_req = 1'b0;
      n = 0;
      while (!a_wait && n < 40) begin @(negedge clk); n++; end
      check("contend_wait", a_wait, 1'b1);
      check("contend_rdata", a_db_o, exp_rd);
      a_dstb = 1'b1;
      wait_drop("contend_drop");
   endtask

   initial begin
      logic [7:0] r;
      logic [7:0] e;
      int         n;
      bit         seen;
      int         k;
      logic [7:0] d;
      logic [AW-1:0] fa;

      rst     = 1'b1;
      a_astb  = 1'b1;
      a_dstb  = 1'b1;
      a_write = 1'b1;
      a_db_i  = 8'h00;
      f_req   = 1'b0;
      f_we    = 1'b0;
      f_addr  = '0;
      f_wdata = 8'h00;
      mdl_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;

      check("rst_a_db_o", a_db_o, 8'h00);
      check("rst_a_db_oe", a_db_oe, 1'b0);
      check("rst_a_wait", a_wait, 1'b0);
      check("rst_addr_reg", addr_reg, 8'h00);
      check("rst_f_gnt", f_gnt, 1'b0);
      check("rst_f_rdata", f_rdata, 8'h00);
      check("rst_f_rvalid", f_rvalid, 1'b0);

      // Arbitration: reset pointer prefers fabric, then alternates.
      mdl_host(0, 8'h03, e);
      host_op(0, 8'h03, r);
      contend(8'h3C, 1'b1, 8'h3C);
      mdl_mem[3] = 8'h3C;
      mdl_bump();
      fab_op(1'b0, 3, 8'h00, r);
      check("fab_read_3", r, 8'h3C);
      mdl_host(0, 8'h03, e);
      host_op(0, 8'h03, r);
      contend(8'h5A, 1'b0, 8'h3C);
      mdl_mem[3] = 8'h5A;
      mdl_bump();
      mdl_host(0, 8'h03, e);
      host_op(0, 8'h03, r);
      mdl_host(3, 8'h00, e);
      host_op(3, 8'h00, r);
      check("contend_after", r, 8'h5A);

`ifdef DEPP_AUTOINC_EN
      add_vec(0, 8'hFF, 8'hFF);
      add_vec(2, 8'h11, 8'h00);
      add_vec(2, 8'h22, 8'h01);
      add_vec(1, 8'h00, 8'h01);
      add_vec(0, 8'h0F, 8'h0F);
      add_vec(3, 8'h00, 8'h11);
      add_vec(0, 8'h00, 8'h00);
      add_vec(3, 8'h00, 8'h22);
      add_vec(1, 8'h00, 8'h01);
`else
      add_vec(0, 8'h05, 8'h05);
      add_vec(1, 8'h00, 8'h05);
      add_vec(0, 8'h03, 8'h03);
      add_vec(2, 8'hA5, 8'h03);
      add_vec(3, 8'h00, 8'hA5);
      add_vec(3, 8'h00, 8'hA5);
      add_vec(0, 8'h13, 8'h13);
      add_vec(3, 8'h00, 8'hA5);
      add_vec(1, 8'h00, 8'h13);
      add_vec(0, 8'h0F, 8'h0F);
      add_vec(2, 8'h7E, 8'h0F);
      add_vec(0, 8'hFF, 8'hFF);
      add_vec(3, 8'h00, 8'h7E);
      add_vec(1, 8'h00, 8'hFF);
`endif
      for (int i = 0; i < tbl.size(); i++) begin
         host_op(tbl[i].kind, tbl[i].din, r);
         check($sformatf("vec%0d", i), r, tbl[i].exp);
         mdl_host(tbl[i].kind, tbl[i].din, e);
      end

      // a_wait latency for a data read with the fabric idle.
      fab_op(1'b1, 9, 8'h6B, r);
      mdl_mem[9] = 8'h6B;
      mdl_host(0, 8'h09, e);
      host_op(0, 8'h09, r);
      @(negedge clk);
      a_write = 1'b1;
      a_dstb  = 1'b0;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!a_wait && n < 40);
      check("wait_rise_latency", n, SYNC + 4);
      check("timed_oe", a_db_oe, 1'b1);
      check("timed_data", a_db_o, 8'h6B);
      mdl_bump();
      @(negedge clk);
      a_dstb = 1'b1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (a_wait && n < 40);
      check("wait_drop_latency", n, SYNC + 1);
      check("timed_oe_drop", a_db_oe, 1'b0);

      // Both strobes fall together: only the address cycle happens.
      fab_op(1'b1, 7, 8'hC3, r);
      mdl_mem[7] = 8'hC3;
      @(negedge clk);
      a_write = 1'b0;
      a_db_i  = 8'h07;
      a_astb  = 1'b0;
      a_dstb  = 1'b0;
      n = 0;
      while (!a_wait && n < 40) begin @(negedge clk); n++; end
      check("both_wait", a_wait, 1'b1);
      a_astb = 1'b1;
      a_dstb = 1'b1;
      wait_drop("both_drop");
      a_write = 1'b1;
      check("both_addr", addr_reg, 8'h07);
      mdl_addr = 8'h07;
      mdl_host(3, 8'h00, e);
      host_op(3, 8'h00, r);
      check("both_mem_kept", r, e);

      // Randomized traffic against the model.
      for (int i = 0; i < 60; i++) begin
         k  = $urandom_range(0, 5);
         d  = 8'($urandom);
         fa = AW'($urandom);
         if (k < 4) begin
            mdl_host(k, d, e);
            host_op(k, d, r);
            check($sformatf("rnd%0d_host%0d", i, k), r, e);
         end else if (k == 4) begin
            fab_op(1'b1, fa, d, r);
            mdl_mem[fa] = d;
         end else begin
            fab_op(1'b0, fa, d, r);
            check($sformatf("rnd%0d_fabrd", i), r, mdl_mem[fa]);
         end
      end

      // Reset during HOLD with dstb still low.
      @(negedge clk);
      a_write = 1'b1;
      a_dstb  = 1'b0;
      n = 0;
      while (!a_wait && n < 40) begin @(negedge clk); n++; end
      check("pre_rst_wait", a_wait, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mdl_reset();
      check("mid_rst_a_wait", a_wait, 1'b0);
      check("mid_rst_oe", a_db_oe, 1'b0);
      check("mid_rst_db_o", a_db_o, 8'h00);
      check("mid_rst_addr", addr_reg, 8'h00);
      check("mid_rst_rvalid", f_rvalid, 1'b0);
      check("mid_rst_rdata", f_rdata, 8'h00);
      seen = 1'b0;
      repeat (12) begin @(negedge clk); if (a_wait) seen = 1'b1; end
      a_dstb = 1'b1;
      repeat (8) begin @(negedge clk); if (a_wait) seen = 1'b1; end
      check("no_xfer_after_rst", seen, 1'b0);
      mdl_host(3, 8'h00, e);
      host_op(3, 8'h00, r);
      check("mem_cleared", r, e);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
